// File: rtl/jk_cmd_arbiter.sv
// jk_cmd_arbiter: arbitrates JK commands from NREQ requesters onto a JK bank.
// One command is granted per IDLE cycle and applied to its bit in the
// following APPLY cycle, so the block takes one command every two cycles.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester command valid
//   req_ready  : per-requester accept (combinational, at most one bit high)
//   req_cmd    : 2-bit command per requester (00 hold, 01 reset, 10 set, 11 toggle)
//   req_idx    : IDXW-bit target bit index per requester
//   j_out/k_out: one-hot (or zero) JK drive for the APPLY cycle
//   q          : JK bank state
//   busy       : high during APPLY
//   gnt_id     : index of the last granted requester
//   err        : pulses during APPLY when the index was >= WIDTH
//
// Build option: define JK_CMD_ARBITER_FIXED_PRIO_EN to replace the
// round-robin search with fixed priority (lowest valid index wins).

module jk_cmd_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 3,
    localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [2*NREQ-1:0]    req_cmd,
    input  logic [IDXW*NREQ-1:0] req_idx,
    output logic [WIDTH-1:0]     j_out,
    output logic [WIDTH-1:0]     k_out,
    output logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic [GW-1:0]        gnt_id,
    output logic                 err
);

    typedef enum logic {
        IDLE,
        APPLY
    } state_t;

    state_t          state;
    logic            found;
    logic [GW-1:0]   win;
    logic [GW-1:0]   cand;
    logic [1:0]      sel_cmd;
    logic [IDXW-1:0] sel_idx;
    logic            in_range;
    logic [WIDTH-1:0] onehot;

`ifndef JK_CMD_ARBITER_FIXED_PRIO_EN
    logic [GW-1:0]   rr_ptr;
    int              c;
`endif

    // Winner search and selection of the winner's command fields.
    always_comb begin
        found   = 1'b0;
        win     = '0;
        cand    = '0;
        sel_cmd = '0;
        sel_idx = '0;
`ifdef JK_CMD_ARBITER_FIXED_PRIO_EN
        for (int o = 0; o < NREQ; o++) begin
            cand = GW'(o);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
`else
        c = 0;
        // Scan from rr_ptr upward, wrapping past NREQ-1.
        for (int o = 0; o < NREQ; o++) begin
            c = int'(rr_ptr) + o;
            if (c >= NREQ)
                c = c - NREQ;
            cand = GW'(c);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
`endif
        for (int o = 0; o < NREQ; o++) begin
            if (GW'(o) == win) begin
                sel_cmd = req_cmd[2*o +: 2];
                sel_idx = req_idx[IDXW*o +: IDXW];
            end
        end
    end

    assign in_range = (32'(sel_idx) < 32'(WIDTH));
    assign onehot   = in_range ? (WIDTH'(1) << sel_idx) : '0;

    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst && found)
            req_ready[win] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q      <= '0;
            j_out  <= '0;
            k_out  <= '0;
            busy   <= 1'b0;
            err    <= 1'b0;
            gnt_id <= '0;
`ifndef JK_CMD_ARBITER_FIXED_PRIO_EN
            rr_ptr <= '0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state  <= APPLY;
                        busy   <= 1'b1;
                        gnt_id <= win;
`ifndef JK_CMD_ARBITER_FIXED_PRIO_EN
                        rr_ptr <= (win == GW'(NREQ - 1)) ? '0 : win + 1'b1;
`endif
                        // cmd[1] drives j, cmd[0] drives k.
                        j_out  <= sel_cmd[1] ? onehot : '0;
                        k_out  <= sel_cmd[0] ? onehot : '0;
                        err    <= !in_range;
                    end
                end
                APPLY: begin
                    // JK rule bitwise; bits with j=k=0 hold.
                    q     <= (j_out & ~q) | (~k_out & q);
                    j_out <= '0;
                    k_out <= '0;
                    busy  <= 1'b0;
                    err   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_cmd_arbiter.sv
// tb_jk_cmd_arbiter: directed self-checking bench for jk_cmd_arbiter.
// A second instance with WIDTH=6 covers out-of-range indices.

module tb_jk_cmd_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [7:0]  req_cmd;
    logic [11:0] req_idx;
    logic [7:0]  j_out, k_out, q;
    logic        busy, err;
    logic [1:0]  gnt_id;

    logic [3:0]  v6, ready6;
    logic [7:0]  c6;
    logic [11:0] i6;
    logic [5:0]  j6, k6, q6;
    logic        busy6, err6;
    logic [1:0]  gnt6;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    jk_cmd_arbiter #(.NREQ(4), .WIDTH(8), .IDXW(3)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_idx(req_idx),
        .j_out(j_out), .k_out(k_out), .q(q),
        .busy(busy), .gnt_id(gnt_id), .err(err)
    );

    jk_cmd_arbiter #(.NREQ(4), .WIDTH(6), .IDXW(3)) u_dut6 (
        .clk(clk), .rst(rst),
        .req_valid(v6), .req_ready(ready6),
        .req_cmd(c6), .req_idx(i6),
        .j_out(j6), .k_out(k6), .q(q6),
        .busy(busy6), .gnt_id(gnt6), .err(err6)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(int r, logic [1:0] c, logic [2:0] i);
        req_valid    = '0;
        req_valid[r] = 1'b1;
        req_cmd[2*r +: 2] = c;
        req_idx[3*r +: 3] = i;
        @(negedge clk);
        chk("send_ready", 32'(req_ready), 32'(1) << r);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    logic [1:0] seq_cmd [5] = '{2'b10, 2'b00, 2'b11, 2'b01, 2'b11};
    logic       seq_q   [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       prev;

    initial begin
        rst = 1'b1;
        req_valid = 4'b0001;
        req_cmd = '0;
        req_idx = '0;
        v6 = '0; c6 = '0; i6 = '0;

        // Reset state, ready suppressed under reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_j", 32'(j_out), 32'h0);
        chk("rst_k", 32'(k_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_gnt", 32'(gnt_id), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;

        // Single set from requester 2 on idx 5
        req_valid = 4'b0100;
        req_cmd[5:4] = 2'b10;
        req_idx[8:6] = 3'd5;
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'h4);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        chk("t1_busy", 32'(busy), 32'h1);
        chk("t1_j", 32'(j_out), 32'h20);
        chk("t1_k", 32'(k_out), 32'h0);
        chk("t1_err", 32'(err), 32'h0);
        @(posedge clk); #1;
        chk("t1_q", 32'(q), 32'h20);
        chk("t1_gnt", 32'(gnt_id), 32'h2);
        chk("t1_busy_end", 32'(busy), 32'h0);
        chk("t1_j_end", 32'(j_out), 32'h0);

        // set, hold, toggle, reset, toggle on idx 0
        prev = 1'b0;
        for (int n = 0; n < 5; n++) begin
            req_valid = 4'b0001;
            req_cmd[1:0] = seq_cmd[n];
            req_idx[2:0] = 3'd0;
            @(negedge clk);
            chk("t2_ready", 32'(req_ready), 32'h1);
            @(posedge clk); #1;
            req_valid = '0;
            @(negedge clk);
            chk("t2_q_before", 32'(q[0]), 32'(prev));
            @(posedge clk); #1;
            chk("t2_q_after", 32'(q[0]), 32'(seq_q[n]));
            chk("t2_q_others", 32'(q[7:1]), 32'h10);
            prev = seq_q[n];
        end

        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
`ifdef JK_CMD_ARBITER_FIXED_PRIO_EN
        // Fixed priority: requester 0 always wins over 3
        req_valid = 4'b1001;
        req_cmd = '0;
        req_idx = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k % 2 == 0)
                chk("fp_ready", 32'(req_ready), 32'h1);
            @(posedge clk); #1;
        end
        req_valid = 4'b1000;
        @(negedge clk);
        chk("fp_ready3", 32'(req_ready), 32'h8);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        chk("fp_gnt3", 32'(gnt_id), 32'h3);
`else
        // Round-robin with all four requesters toggling idx 0..3
        req_valid = 4'hF;
        req_cmd = 8'hFF;
        req_idx = {3'd3, 3'd2, 3'd1, 3'd0};
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k % 2 == 0)
                chk("rr_ready", 32'(req_ready), 32'(1) << ((k / 2) % 4));
            else begin
                chk("rr_ready_apply", 32'(req_ready), 32'h0);
                chk("rr_gnt", 32'(gnt_id), 32'((k / 2) % 4));
            end
            @(posedge clk); #1;
            if (k == 7)
                chk("rr_q8", 32'(q), 32'h0F);
            if (k == 15)
                chk("rr_q16", 32'(q), 32'h00);
        end
        req_valid = '0;
        req_cmd = '0;
        req_idx = '0;
`endif

        // Reset during APPLY
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send(0, 2'b10, 3'd0);
        send(0, 2'b10, 3'd7);
        chk("t4_q81", 32'(q), 32'h81);
        req_valid = 4'b0100;
        req_cmd[5:4] = 2'b10;
        req_idx[8:6] = 3'd3;
        @(posedge clk); #1;
        req_valid = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("t4_busy_apply", 32'(busy), 32'h1);
        chk("t4_j_apply", 32'(j_out), 32'h08);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t4_q", 32'(q), 32'h0);
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_gnt", 32'(gnt_id), 32'h0);
        req_valid = 4'b1010;
        req_cmd = '0;
        req_idx = '0;
        @(negedge clk);
        chk("t4_ready", 32'(req_ready), 32'h2);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        chk("t4_q_end", 32'(q), 32'h0);

        // Out-of-range index on the WIDTH=6 instance
        v6 = 4'b0001;
        c6[1:0] = 2'b10;
        i6[2:0] = 3'd5;
        @(negedge clk);
        chk("t5_ready0", 32'(ready6), 32'h1);
        @(posedge clk); #1;
        v6 = '0;
        @(posedge clk); #1;
        chk("t5_q_set", 32'(q6), 32'h20);
        v6 = 4'b0010;
        c6[3:2] = 2'b10;
        i6[5:3] = 3'd7;
        @(negedge clk);
        chk("t5_ready1", 32'(ready6), 32'h2);
        @(posedge clk); #1;
        v6 = '0;
        @(negedge clk);
        chk("t5_err", 32'(err6), 32'h1);
        chk("t5_j", 32'(j6), 32'h0);
        chk("t5_k", 32'(k6), 32'h0);
        chk("t5_busy", 32'(busy6), 32'h1);
        @(posedge clk); #1;
        chk("t5_err_end", 32'(err6), 32'h0);
        chk("t5_q", 32'(q6), 32'h20);
        chk("t5_gnt", 32'(gnt6), 32'h1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
